// File: rtl/inst_encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: opcodes, funct3 values,
// ALU operations, FSM states, fault codes and a signed-range helper.
package inst_encoder_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

  localparam logic [2:0] FNC_ADD_SUB = 3'b000;
  localparam logic [2:0] FNC_SLL     = 3'b001;
  localparam logic [2:0] FNC_SLT     = 3'b010;
  localparam logic [2:0] FNC_SLTU    = 3'b011;
  localparam logic [2:0] FNC_XOR     = 3'b100;
  localparam logic [2:0] FNC_SRL_SRA = 3'b101;
  localparam logic [2:0] FNC_OR      = 3'b110;
  localparam logic [2:0] FNC_AND     = 3'b111;

  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SRL    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_OPCODE = 3'd1;
  localparam logic [2:0] ERR_ALUOP  = 3'd2;
  localparam logic [2:0] ERR_IMM    = 3'd3;
  localparam logic [2:0] ERR_FUNCT3 = 3'd4;
  localparam logic [2:0] ERR_ADDR   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } enc_state_e;

  // True when value is representable as a two's-complement number of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
    logic [31:0] upper;
    upper = $signed(value) >>> (bits - 32'd1);
    return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_packer.sv
// Places an immediate into its RV32I format bit positions (all other bits zero)
// and flags values the format cannot represent. Shift immediates are handled by the caller.
module inst_encoder_imm_packer
  import inst_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [31:0] imm_i,
  output logic [31:0] imm_bits_o,
  output logic        range_fault_o
);

  always_comb begin
    imm_bits_o    = 32'h0000_0000;
    range_fault_o = 1'b0;
    case (opcode_i)
      OPC_ARI_ITYPE, OPC_LOAD, OPC_JALR: begin
        imm_bits_o    = {imm_i[11:0], 20'd0};
        range_fault_o = !fits_signed(imm_i, 32'd12);
      end
      OPC_STORE: begin
        imm_bits_o    = {imm_i[11:5], 13'd0, imm_i[4:0], 7'd0};
        range_fault_o = !fits_signed(imm_i, 32'd12);
      end
      OPC_BRANCH: begin
        imm_bits_o    = {imm_i[12], imm_i[10:5], 13'd0, imm_i[4:1], imm_i[11], 7'd0};
        range_fault_o = !fits_signed(imm_i, 32'd13) || imm_i[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_bits_o    = {imm_i[31:12], 12'd0};
        range_fault_o = (imm_i[11:0] != 12'd0);
      end
      OPC_JAL: begin
        imm_bits_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'd0};
        range_fault_o = !fits_signed(imm_i, 32'd21) || imm_i[0];
      end
      default: begin
        imm_bits_o    = 32'h0000_0000;
        range_fault_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: packs instruction descriptions into 32-bit words and
// writes them to consecutive IMEM addresses, stopping on the last word or a fault.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [3:0]            in_alu_op,
  input  logic [2:0]            in_funct3,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_din,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_code
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  enc_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [2:0]            code_q, code_d;

  logic [31:0] imm_bits_s;
  logic        imm_fault_s;
  logic [2:0]  alu_f3_s;
  logic [6:0]  alu_f7_s;
  logic        alu_ok_s;
  logic        alu_shift_s;
  logic        f3_ok_s;
  logic [31:0] word_s;
  logic [2:0]  code_s;

  inst_encoder_imm_packer u_imm_packer (
    .opcode_i      (in_opcode),
    .imm_i         (in_imm),
    .imm_bits_o    (imm_bits_s),
    .range_fault_o (imm_fault_s)
  );

  // Inverse of the decoder's ALU mapping; ALU_COPY_B has no R/I-type encoding.
  always_comb begin
    alu_f3_s    = FNC_ADD_SUB;
    alu_f7_s    = F7_BASE;
    alu_ok_s    = 1'b1;
    alu_shift_s = 1'b0;
    case (in_alu_op)
      ALU_ADD:  alu_f3_s = FNC_ADD_SUB;
      ALU_SUB:  begin alu_f3_s = FNC_ADD_SUB; alu_f7_s = F7_ALT; end
      ALU_AND:  alu_f3_s = FNC_AND;
      ALU_OR:   alu_f3_s = FNC_OR;
      ALU_XOR:  alu_f3_s = FNC_XOR;
      ALU_SLT:  alu_f3_s = FNC_SLT;
      ALU_SLTU: alu_f3_s = FNC_SLTU;
      ALU_SLL:  begin alu_f3_s = FNC_SLL; alu_shift_s = 1'b1; end
      ALU_SRL:  begin alu_f3_s = FNC_SRL_SRA; alu_shift_s = 1'b1; end
      ALU_SRA:  begin alu_f3_s = FNC_SRL_SRA; alu_f7_s = F7_ALT; alu_shift_s = 1'b1; end
      default:  alu_ok_s = 1'b0;
    endcase
  end

  // funct3 legality for the formats that take funct3 from the input.
  always_comb begin
    f3_ok_s = 1'b1;
    case (in_opcode)
      OPC_LOAD: begin
        case (in_funct3)
          FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU: f3_ok_s = 1'b1;
          default:                                  f3_ok_s = 1'b0;
        endcase
      end
      OPC_STORE: begin
        case (in_funct3)
          FNC_SB, FNC_SH, FNC_SW: f3_ok_s = 1'b1;
          default:                f3_ok_s = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        case (in_funct3)
          FNC_BEQ, FNC_BNE, FNC_BLT, FNC_BGE, FNC_BLTU, FNC_BGEU: f3_ok_s = 1'b1;
          default:                                                f3_ok_s = 1'b0;
        endcase
      end
      OPC_JALR: f3_ok_s = (in_funct3 == 3'b000);
      default:  f3_ok_s = 1'b1;
    endcase
  end

  // Word assembly and fault classification; opcode, ALUop, range, funct3 in that priority.
  always_comb begin
    word_s = imm_bits_s | {25'd0, in_opcode};
    code_s = ERR_NONE;
    case (in_opcode)
      OPC_ARI_RTYPE: begin
        word_s = {alu_f7_s, in_rs2, in_rs1, alu_f3_s, in_rd, in_opcode};
        if (!alu_ok_s) code_s = ERR_ALUOP;
        else           code_s = ERR_NONE;
      end
      OPC_ARI_ITYPE: begin
        if (alu_shift_s) word_s = {alu_f7_s, in_imm[4:0], in_rs1, alu_f3_s, in_rd, in_opcode};
        else             word_s = imm_bits_s | {12'd0, in_rs1, alu_f3_s, in_rd, in_opcode};
        if (!alu_ok_s || (in_alu_op == ALU_SUB))                     code_s = ERR_ALUOP;
        else if (alu_shift_s ? (in_imm[31:5] != 27'd0) : imm_fault_s) code_s = ERR_IMM;
        else                                                          code_s = ERR_NONE;
      end
      OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH: begin
        if ((in_opcode == OPC_LOAD) || (in_opcode == OPC_JALR))
          word_s = imm_bits_s | {12'd0, in_rs1, in_funct3, in_rd, in_opcode};
        else
          word_s = imm_bits_s | {7'd0, in_rs2, in_rs1, in_funct3, 5'd0, in_opcode};
        if (imm_fault_s)   code_s = ERR_IMM;
        else if (!f3_ok_s) code_s = ERR_FUNCT3;
        else               code_s = ERR_NONE;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        word_s = imm_bits_s | {20'd0, in_rd, in_opcode};
        if (imm_fault_s) code_s = ERR_IMM;
        else             code_s = ERR_NONE;
      end
      default: begin
        word_s = 32'h0000_0000;
        code_s = ERR_OPCODE;
      end
    endcase
  end

  // Load-control FSM; start overrides any accept in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = BASE_ADDR;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (in_valid && (code_s != ERR_NONE)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = code_s;
          end else if (in_valid) begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            din_d  = word_s;
            if (cnt_q != ADDR_MAX) cnt_d = cnt_q + ADDR_ONE;
            else                   cnt_d = cnt_q;
            if (in_last) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else if (cnt_q == ADDR_MAX) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              code_d  = ERR_ADDR;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE, ST_DONE, ST_ERR: state_d = state_q;
        default:                  state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_WIDTH{1'b0}};
      we_q    <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      din_q   <= 32'h0000_0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_din  = din_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder and instruction-memory loader: the inverse of the control decoder. It accepts instruction descriptions (opcode, ALUop, funct3, register numbers, immediate) over a valid/ready handshake, packs each into a 32-bit RV32I word, and writes the words to consecutive IMEM addresses. It sits between the test/BIOS program generator and the IMEM write port.

## Interface
- `ADDR_WIDTH`, 12: IMEM word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a program load.
- `in_valid` in 1: instruction description valid.
- `in_ready` out 1: encoder can accept.
- `in_opcode` in 7: `OPC_*` value.
- `in_alu_op` in 4: `ALU_*` value, used only for `OPC_ARI_RTYPE`/`OPC_ARI_ITYPE`.
- `in_funct3` in 3: used only for LOAD/STORE/BRANCH/JALR.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register numbers, ignored where the format lacks them.
- `in_imm` in 32: byte-offset/immediate value, sign-carrying.
- `in_last` in 1: marks the final instruction.
- `imem_we` out 1; `imem_addr` out ADDR_WIDTH; `imem_din` out 32: IMEM write port.
- `done` out 1: load completed.
- `err` out 1; `err_code` out 3: fault flag and cause.

## Operation
- States: IDLE, RUN, DONE, ERR. Reset puts the block in IDLE. All outputs reset to 0.
- `start` in any state: go to RUN, set the address counter to BASE_ADDR, clear `done`, `err`, and `err_code`.
- `in_ready` is 1 only in RUN.
- Accept: `in_valid && in_ready` at an edge.
- On accept, the word is encoded combinationally and registered.
- ALUop→funct3/funct7 mapping is the exact inverse of the decoder:
  - `ALU_SUB`/`ALU_SRA` set funct7 = 0100000 in R-type.
  - In I-type, `ALU_SRA` sets imm[11:5] = 0100000.
  - `ALU_SUB` in I-type is illegal.
  - `ALU_COPY_B` is legal only for LUI.
- Immediate packing per format:
  - I: imm[11:0].
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - B: imm[12|10:5|4:1|11].
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12].
- Legality checks produce `err_code`:
  - 1: unknown opcode.
  - 2: ALUop has no encoding for that opcode.
  - 3: immediate out of range. I/S require a 12-bit signed value. B requires 13-bit signed with bit0 = 0. J requires 21-bit signed with bit0 = 0. U requires imm[11:0] = 0. Shifts require imm[31:5] = 0.
  - 4: funct3 illegal for LOAD/STORE/BRANCH, or nonzero for JALR.
  - 5: address overflow.
- Illegal instruction: go to ERR, no write, and `err` and `err_code` are latched.
- Legal instruction: write the word, then increment the address.
  - With `in_last`: go to DONE and set `done` = 1.
  - Accepted at the address 2^ADDR_WIDTH−1 without `in_last`: write that word, then go to ERR with code 5. The address counter never wraps.
- DONE and ERR hold until `start` or `rst`.
- `start` coinciding with an accept: `start` wins and the input is not consumed.

## Timing
- Latency: accept at edge N → `imem_we` = 1 with the address and data during cycle N+1, written at edge N+1.
- Throughput: one instruction per cycle. `imem_we` is high for exactly one cycle per legal accepted instruction.
- `done`/`err` assert in the same cycle as the final `imem_we` (or in the cycle after an illegal accept). `in_ready` falls at that same edge.
- `rst` mid-load: immediate return to IDLE with all outputs 0. A pending write is dropped.

## Structure
- `OPC_*`, `FNC_*`, and `ALU_*` constants come from the shared Opcode.vh/ALUop.vh.
- `err_code` values and state encodings go in a shared `encoder_defs.vh`.
- One sub-module, `imm_packer`, is natural. It is combinational: opcode + immediate → packed immediate bits plus a range-fault flag.
- The FSM, address counter, and funct mapping stay in the top module.

## Test plan
- `start`, then ADDI x1,x0,5 (ALU_ADD, ITYPE, imm = 5) → `imem_din` = 0x00500093 at addr 0 one cycle after accept.
- Back-to-back SUB x3,x1,x2 then SW x2,8(x1) with `in_last` → 0x402081B3 @0, 0x0020A423 @1, `done` = 1 with the second write.
- BEQ x1,x2,imm = −4 → 0xFE208EE3. Same with imm = −3 → ERR, `err_code` = 3, no write.
- ALU_SUB with ITYPE → `err_code` = 2. SRAI imm = 32 → `err_code` = 3. Opcode 0x7F → `err_code` = 1. `in_ready` = 0 until `start`.
- ADDR_WIDTH = 2, four legal non-last instructions → writes at 0..3, then ERR with `err_code` = 5. The counter does not return to 0.
- `rst` asserted the cycle after an accept → `imem_we` stays 0 and all outputs read 0 immediately. A following `start` restarts at BASE_ADDR.
